// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, PC step,
// the NOP left in a squashed slot, and the redirect alignment check.
package cpu_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// IF/ID output register. Priority is squash > load > consume; contents hold
// while the slot is valid and not consumed.
module fetch_slot
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 9
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_squash,
    input  logic                i_load,
    input  logic                i_consume,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [31:0]         i_inst,
    output logic                o_valid,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [31:0]         o_inst
);

    logic                r_valid;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_inst;

    // Slot state update: a squash wins even over a simultaneous load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= {PC_WIDTH{1'b0}};
            r_inst  <= 32'h0000_0000;
        end else if (i_squash) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the architectural PC, issues instruction-memory requests and
// delivers {PC, instruction} pairs to IF/ID, dropping wrong-path fetches on redirect.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCSel,
    input  logic [31:0]         PCBranch,
    output logic                ImemReq,
    output logic [PC_WIDTH-1:0] ImemAddr,
    input  logic                ImemGnt,
    input  logic                ImemRValid,
    input  logic [31:0]         ImemRData,
    output logic                IfValid,
    input  logic                IfReady,
    output logic [PC_WIDTH-1:0] IfPC,
    output logic [31:0]         IfInst,
    output logic                MisalignErr
);

    localparam logic [PC_WIDTH-1:0] L_STEP = PC_WIDTH'(PC_STEP);

    fetch_state_t        r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_req_pc;
    logic                r_drop;
    logic                r_misalign;

    logic                w_if_valid;
    logic                w_slot_free;
    logic                w_req;
    logic                w_grant;
    logic                w_resp;
    logic                w_load;
    logic                w_consume;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_unused_hi;

    // A request only issues when the slot can take its response next cycle.
    assign w_slot_free = !w_if_valid || IfReady;
    assign w_req       = !reset && (r_state == FETCH) && w_slot_free;
    assign w_grant     = w_req && ImemGnt;
    assign w_resp      = (r_state == WAIT) && ImemRValid;
    assign w_load      = w_resp && !r_drop && !PCSel;
    assign w_consume   = w_if_valid && IfReady;
    assign w_target    = {PCBranch[PC_WIDTH-1:2], 2'b00};
    assign w_unused_hi = ^PCBranch[31:PC_WIDTH];

    // Fetch FSM, PC and sticky misalignment flag; a redirect overrides PC+4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_req_pc   <= {PC_WIDTH{1'b0}};
            r_drop     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (PCSel && misaligned(PCBranch[1:0])) begin
                r_misalign <= 1'b1;
            end

            case (r_state)
                FETCH: begin
                    if (w_grant) begin
                        r_state  <= WAIT;
                        r_req_pc <= r_pc;
                        r_drop   <= PCSel;
                    end
                end
                WAIT: begin
                    if (ImemRValid) begin
                        r_state <= FETCH;
                        r_drop  <= 1'b0;
                    end else if (PCSel) begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FETCH;
                    r_drop  <= 1'b0;
                end
            endcase

            if (PCSel) begin
                r_pc <= w_target;
            end else if (w_grant) begin
                r_pc <= r_pc + L_STEP;
            end
        end
    end

    fetch_slot #(
        .PC_WIDTH (PC_WIDTH)
    ) u_slot (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_squash  (PCSel),
        .i_load    (w_load),
        .i_consume (w_consume),
        .i_pc      (r_req_pc),
        .i_inst    (ImemRData),
        .o_valid   (w_if_valid),
        .o_pc      (IfPC),
        .o_inst    (IfInst)
    );

    assign ImemReq     = w_req;
    assign ImemAddr    = r_pc;
    assign IfValid     = w_if_valid;
    assign MisalignErr = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a transaction-level model is compared to the
// DUT every cycle, and literal expectations pin the address/delivery sequences.
module tb_pc_fetch_unit;

    localparam int PW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, PCSel, ImemGnt, ImemRValid, IfReady;
    logic [31:0]   PCBranch, ImemRData;
    logic          ImemReq, IfValid, MisalignErr;
    logic [PW-1:0] ImemAddr, IfPC;
    logic [31:0]   IfInst;

    logic          w2_req, rv2;
    logic [PW-1:0] w2_addr;
    logic          unused_w2_valid, unused_w2_err;
    logic [PW-1:0] unused_w2_pc;
    logic [31:0]   unused_w2_inst;

    pc_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(9'd0)) dut (
        .clk(clk), .reset(reset), .PCSel(PCSel), .PCBranch(PCBranch),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .IfValid(IfValid), .IfReady(IfReady), .IfPC(IfPC), .IfInst(IfInst),
        .MisalignErr(MisalignErr)
    );

    pc_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(9'd508)) dut_wrap (
        .clk(clk), .reset(reset), .PCSel(1'b0), .PCBranch(32'h0000_0000),
        .ImemReq(w2_req), .ImemAddr(w2_addr), .ImemGnt(1'b1),
        .ImemRValid(rv2), .ImemRData(32'h0000_0013),
        .IfValid(unused_w2_valid), .IfReady(1'b1), .IfPC(unused_w2_pc),
        .IfInst(unused_w2_inst), .MisalignErr(unused_w2_err)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
        return {16'hC0DE, 7'h00, a};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model state: next fetch address, one outstanding request, the IF/ID slot.
    logic [PW-1:0] m_pc, m_req_addr, m_spc;
    logic          m_busy, m_drop, m_sv, m_err;
    logic [31:0]   m_sinst;

    logic          hs_last, hs2, stray_ok;
    logic [PW-1:0] hs_addr;
    int            cyc = 0;
    logic [PW-1:0] grant_log[$];
    logic [PW-1:0] dlv_pc[$];
    logic [31:0]   dlv_inst[$];
    int            dlv_cyc[$];
    logic [PW-1:0] wrap_log[$];

    // Compare DUT against the model mid-cycle, then advance the model by the rules.
    always @(negedge clk) begin : compare_model
        logic exp_req, grant, resp, consume;
        logic [PW-1:0] tgt;
        cyc++;
        if (reset) begin
            m_pc = 9'd0; m_busy = 1'b0; m_drop = 1'b0; m_sv = 1'b0; m_err = 1'b0;
        end
        exp_req = !reset && !m_busy && (!m_sv || IfReady);
        check("ImemReq", {63'd0, ImemReq}, {63'd0, exp_req});
        if (!reset && !m_busy) check("ImemAddr", {55'd0, ImemAddr}, {55'd0, m_pc});
        check("IfValid", {63'd0, IfValid}, {63'd0, m_sv});
        if (m_sv) begin
            check("IfPC", {55'd0, IfPC}, {55'd0, m_spc});
            check("IfInst", {32'd0, IfInst}, {32'd0, m_sinst});
        end
        check("MisalignErr", {63'd0, MisalignErr}, {63'd0, m_err});
        if (!reset) begin
            assert (!ImemRValid || m_busy || stray_ok)
                else $error("protocol: ImemRValid with no outstanding request");
        end

        hs_last = !reset && ImemReq && ImemGnt;
        hs_addr = ImemAddr;
        if (hs_last) grant_log.push_back(ImemAddr);
        if (!reset && IfValid && IfReady) begin
            dlv_pc.push_back(IfPC);
            dlv_inst.push_back(IfInst);
            dlv_cyc.push_back(cyc);
        end
        hs2 = !reset && w2_req;
        if (hs2 && wrap_log.size() < 4) wrap_log.push_back(w2_addr);

        if (!reset) begin
            grant   = exp_req && ImemGnt;
            resp    = m_busy && ImemRValid;
            consume = m_sv && IfReady;
            tgt     = PW'(PCBranch & 32'h0000_01FC);
            if (consume) m_sv = 1'b0;
            if (resp) begin
                if (!m_drop && !PCSel) begin
                    m_sv = 1'b1; m_spc = m_req_addr; m_sinst = mem_word(m_req_addr);
                end
                m_busy = 1'b0; m_drop = 1'b0;
            end
            if (grant) begin
                m_busy = 1'b1; m_req_addr = m_pc; m_drop = PCSel; m_pc = m_pc + 9'd4;
            end
            if (PCSel) begin
                if (m_busy) m_drop = 1'b1;
                m_sv = 1'b0;
                m_pc = tgt;
                if (PCBranch[1:0] != 2'b00) m_err = 1'b1;
            end
        end
    end

    int            rsp_lat = 1;
    logic          rsp_busy = 1'b0;
    logic [PW-1:0] rsp_addr;
    int            rsp_wait;

    // One clock cycle; the memory answers a grant after rsp_lat cycles.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
        ImemRValid = 1'b0;
        rv2 = hs2;
        if (hs_last) begin
            rsp_busy = 1'b1; rsp_addr = hs_addr; rsp_wait = rsp_lat - 1;
        end
        if (rsp_busy) begin
            if (rsp_wait == 0) begin
                ImemRValid = 1'b1; ImemRData = mem_word(rsp_addr); rsp_busy = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_until_hs(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!hs_last && n < 50);
        check(tag, {63'd0, hs_last}, 64'd1);
    endtask

    task automatic clear_logs();
        grant_log.delete(); dlv_pc.delete(); dlv_inst.delete(); dlv_cyc.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [PW-1:0] saved_pc, dropped;
        logic [63:0]   big;
        bit            seen;
        reset = 1'b1; PCSel = 1'b0; PCBranch = 32'h0; ImemGnt = 1'b0;
        ImemRValid = 1'b0; ImemRData = 32'h0; IfReady = 1'b1; rv2 = 1'b0; stray_ok = 1'b0;
        ticks(3);
        check("rst IfValid", {63'd0, IfValid}, 64'd0);
        check("rst ImemReq", {63'd0, ImemReq}, 64'd0);
        check("rst IfPC", {55'd0, IfPC}, 64'd0);
        check("rst IfInst", {32'd0, IfInst}, 64'd0);
        check("rst Misalign", {63'd0, MisalignErr}, 64'd0);

        // Zero-wait streaming from reset
        reset = 1'b0; ImemGnt = 1'b1; clear_logs();
        ticks(7);
        check("seq count", {63'd0, (grant_log.size() >= 3 && dlv_pc.size() >= 3)}, 64'd1);
        if (grant_log.size() >= 3 && dlv_pc.size() >= 3) begin
            check("addr0", {55'd0, grant_log[0]}, 64'h0);
            check("addr1", {55'd0, grant_log[1]}, 64'h4);
            check("addr2", {55'd0, grant_log[2]}, 64'h8);
            check("ifpc0", {55'd0, dlv_pc[0]}, 64'h0);
            check("ifpc1", {55'd0, dlv_pc[1]}, 64'h4);
            check("ifpc2", {55'd0, dlv_pc[2]}, 64'h8);
            check("inst0", {32'd0, dlv_inst[0]}, 64'hC0DE_0000);
            check("inst2", {32'd0, dlv_inst[2]}, 64'hC0DE_0008);
            check("rate", 64'(dlv_cyc[1] - dlv_cyc[0]), 64'd2);
        end

        // Backpressure: full slot blocks requests
        IfReady = 1'b0;
        ticks(3);
        #1;
        check("bp full", {63'd0, IfValid}, 64'd1);
        saved_pc = IfPC;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp req", {63'd0, ImemReq}, 64'd0);
            check("bp pc stable", {55'd0, IfPC}, {55'd0, saved_pc});
        end
        IfReady = 1'b1;
        #1;
        check("bp resume", {63'd0, ImemReq}, 64'd1);
        tick();

        // Redirect while the request is outstanding
        rsp_lat = 3;
        tick_until_hs("t3 grant");
        dropped = hs_addr;
        PCSel = 1'b1; PCBranch = 32'h0000_0040;
        tick();
        PCSel = 1'b0; clear_logs();
        ticks(10);
        check("t3 count", {63'd0, (grant_log.size() >= 1 && dlv_pc.size() >= 1)}, 64'd1);
        if (grant_log.size() >= 1 && dlv_pc.size() >= 1) begin
            check("t3 addr", {55'd0, grant_log[0]}, 64'h40);
            check("t3 ifpc", {55'd0, dlv_pc[0]}, 64'h40);
        end
        seen = 1'b0;
        foreach (dlv_pc[i]) if (dlv_pc[i] == dropped) seen = 1'b1;
        check("t3 dropped absent", {63'd0, seen}, 64'd0);

        // Redirect in the same cycle as the response
        rsp_lat = 1;
        tick_until_hs("t4 grant");
        PCSel = 1'b1; PCBranch = 32'h0000_0080; clear_logs();
        tick();
        PCSel = 1'b0;
        #1;
        check("t4 req", {63'd0, ImemReq}, 64'd1);
        check("t4 addr", {55'd0, ImemAddr}, 64'h80);
        ticks(4);
        check("t4 count", {63'd0, (dlv_pc.size() >= 1)}, 64'd1);
        if (dlv_pc.size() >= 1) check("t4 ifpc", {55'd0, dlv_pc[0]}, 64'h80);

        // Misaligned, over-wide target while idle in FETCH
        ImemGnt = 1'b0;
        ticks(4);
        big = 64'h1_0000_0102;
        PCSel = 1'b1; PCBranch = big[31:0];
        tick();
        PCSel = 1'b0;
        #1;
        check("t5 addr", {55'd0, ImemAddr}, 64'h100);
        check("t5 err", {63'd0, MisalignErr}, 64'd1);
        ImemGnt = 1'b1; clear_logs();
        ticks(4);
        if (grant_log.size() >= 1) check("t5 grant", {55'd0, grant_log[0]}, 64'h100);
        else check("t5 grant count", 64'd0, 64'd1);
        PCSel = 1'b1; PCBranch = 32'h0000_0020;
        tick();
        PCSel = 1'b0;
        ticks(3);
        check("t5 sticky", {63'd0, MisalignErr}, 64'd1);

        // Reset in WAIT, late response afterwards
        rsp_lat = 3;
        tick_until_hs("t6 grant");
        ImemGnt = 1'b0; reset = 1'b1; stray_ok = 1'b1;
        #1;
        check("t6 valid", {63'd0, IfValid}, 64'd0);
        check("t6 req", {63'd0, ImemReq}, 64'd0);
        check("t6 err", {63'd0, MisalignErr}, 64'd0);
        tick();
        reset = 1'b0; clear_logs();
        ticks(3);
        check("t6 late ignored", {63'd0, IfValid}, 64'd0);
        check("t6 no delivery", 64'(dlv_pc.size()), 64'd0);
        stray_ok = 1'b0; ImemGnt = 1'b1;
        ticks(5);
        if (grant_log.size() >= 1) check("t6 restart", {55'd0, grant_log[0]}, 64'h0);
        else check("t6 restart count", 64'd0, 64'd1);

        // RESET_PC = 508 instance wraps to 0
        check("wrap count", {63'd0, (wrap_log.size() >= 2)}, 64'd1);
        if (wrap_log.size() >= 2) begin
            check("wrap addr0", {55'd0, wrap_log[0]}, 64'd508);
            check("wrap addr1", {55'd0, wrap_log[1]}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
